mem_arbiter_n: RTL and testbench

- Parametrised N-master arbiter for the shared memory bus, replacing the fixed two-port instruction-fetch/memory-access mux.
- Serialises requests from IF, MEM and future masters (DMA, debug) onto one slave port.
- Supports multi-cycle slaves through a ready handshake.
- Returns per-master stall and done signals; pipeline stages consume these in place of the single global stall.

---
 rtl/mem_arbiter_n_pkg.sv | 28 ++
 rtl/mem_arbiter_n_if.sv | 56 +++++
 rtl/mem_arbiter_n_arb_pick.sv | 37 +++
 rtl/mem_arbiter_n.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter_n.sv | 371 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and helpers for the N-master memory bus arbiter.
// Holds the FSM encoding, arbitration mode codes and a one-hot decoder.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int ARB_FIXED   = 0;
    localparam int ARB_RR      = 1;
    localparam int MAX_MASTERS = 32;

    // Assumes a true one-hot (or zero) input.
    function automatic int unsigned oh_to_idx(
        input logic [MAX_MASTERS-1:0] oh
    );
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_MASTERS; i++) begin
            if (oh[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Bundle of the master request side and the shared slave bus.
// master: the arbiter that owns the slave port; slave: everything around it.
interface mem_arbiter_n_if #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64
);

    logic [N_MASTERS-1:0]        m_req;
    logic [N_MASTERS-1:0]        m_write;
    logic [N_MASTERS*ADDR_W-1:0] m_addr;
    logic [N_MASTERS*DATA_W-1:0] m_wdata;
    logic [N_MASTERS-1:0]        m_stall;
    logic [N_MASTERS-1:0]        m_done;
    logic [DATA_W-1:0]           m_rdata;

    logic              s_valid;
    logic              s_write;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              s_ready;
    logic [DATA_W-1:0] s_rdata;

    modport master (
        input  m_req,
        input  m_write,
        input  m_addr,
        input  m_wdata,
        output m_stall,
        output m_done,
        output m_rdata,
        output s_valid,
        output s_write,
        output s_addr,
        output s_wdata,
        input  s_ready,
        input  s_rdata
    );

    modport slave (
        output m_req,
        output m_write,
        output m_addr,
        output m_wdata,
        input  m_stall,
        input  m_done,
        input  m_rdata,
        input  s_valid,
        input  s_write,
        input  s_addr,
        input  s_wdata,
        output s_ready,
        output s_rdata
    );

endinterface

// File: rtl/mem_arbiter_n_arb_pick.sv
// Rotating-priority picker: first eligible index at or after start_ptr.
// A start_ptr of zero gives plain fixed priority.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] start_ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    logic [MAX_MASTERS-1:0] oh;
    int                     j;

    // Walk from the far end so the closest candidate overwrites last.
    always_comb begin
        oh = '0;
        j  = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start_ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (eligible[j]) begin
                oh    = '0;
                oh[j] = 1'b1;
            end
        end
    end

    assign grant_valid = |eligible;
    assign grant_idx   = IW'(oh_to_idx(oh));

endmodule

// File: rtl/mem_arbiter_n.sv
// N-master arbiter serialising requests onto one ready-handshake slave.
// Define ARB_STARVE_GUARD_EN to force grants after STARVE_LIMIT waits.
module mem_arbiter_n
    import mem_arb_pkg::*;
#(
    parameter int N_MASTERS    = 2,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 8
) (
    input logic            CLK,
    input logic            RESET,
    mem_arbiter_n_if.master bus
);

    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    state_t               state, state_n;
    logic [IW-1:0]        owner, owner_n;
    logic [IW-1:0]        rr_ptr, rr_ptr_n;
    logic                 s_valid_q, s_valid_n;
    logic                 s_write_q, s_write_n;
    logic [ADDR_W-1:0]    s_addr_q, s_addr_n;
    logic [DATA_W-1:0]    s_wdata_q, s_wdata_n;
    logic [N_MASTERS-1:0] m_done_q, m_done_n;
    logic [DATA_W-1:0]    m_rdata_q, m_rdata_n;

    logic                 finish;
    logic                 load;
    logic [N_MASTERS-1:0] mask;
    logic [N_MASTERS-1:0] eligible;
    logic                 pick_valid;
    logic [IW-1:0]        pick_idx;
    logic [IW-1:0]        start_ptr;
    logic [IW-1:0]        win_idx;

    assign finish = (state == BUSY) && bus.s_ready;

    // The finishing master still holds m_req this cycle; keep it out.
    always_comb begin
        mask = '0;
        if (finish) begin
            mask[owner] = 1'b1;
        end
    end

    assign eligible  = bus.m_req & ~mask;
    assign start_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

    arb_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .eligible    (eligible),
        .start_ptr   (start_ptr),
        .grant_valid (pick_valid),
        .grant_idx   (pick_idx)
    );

    assign load = pick_valid && ((state == IDLE) || finish);

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]          wait_cnt [N_MASTERS];
    logic [N_MASTERS-1:0]   starving;
    logic [N_MASTERS-1:0]   granted;
    logic [MAX_MASTERS-1:0] starve_oh;

    always_comb begin
        starving  = '0;
        starve_oh = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            starving[i] = eligible[i] &&
                (wait_cnt[i] == CW'(STARVE_LIMIT));
            if (starving[i]) begin
                starve_oh    = '0;
                starve_oh[i] = 1'b1;
            end
        end
    end

    assign win_idx = (|starving) ?
        IW'(oh_to_idx(starve_oh)) : pick_idx;

    always_comb begin
        granted = '0;
        if (load) begin
            granted[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!bus.m_req[i] || granted[i]) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CW'(STARVE_LIMIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign win_idx = pick_idx;
`endif

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_ptr_n  = rr_ptr;
        s_valid_n = s_valid_q;
        s_write_n = s_write_q;
        s_addr_n  = s_addr_q;
        s_wdata_n = s_wdata_q;
        m_done_n  = '0;
        m_rdata_n = m_rdata_q;
        unique case (state)
            IDLE: begin
            end
            BUSY: begin
                if (finish) begin
                    m_done_n[owner] = 1'b1;
                    m_rdata_n       = bus.s_rdata;
                    if (!load) begin
                        s_valid_n = 1'b0;
                        state_n   = IDLE;
                    end
                end
            end
        endcase
        if (load) begin
            state_n   = BUSY;
            owner_n   = win_idx;
            rr_ptr_n  = (win_idx == IW'(N_MASTERS - 1)) ?
                '0 : win_idx + 1'b1;
            s_valid_n = 1'b1;
            s_write_n = bus.m_write[win_idx];
            s_addr_n  = bus.m_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            s_wdata_n = bus.m_wdata[int'(win_idx)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            s_valid_q <= 1'b0;
            s_write_q <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            m_done_q  <= '0;
            m_rdata_q <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            s_valid_q <= s_valid_n;
            s_write_q <= s_write_n;
            s_addr_q  <= s_addr_n;
            s_wdata_q <= s_wdata_n;
            m_done_q  <= m_done_n;
            m_rdata_q <= m_rdata_n;
        end
    end

    assign bus.s_valid = s_valid_q;
    assign bus.s_write = s_write_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.m_done  = m_done_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.m_stall = bus.m_req & ~m_done_q;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Bench for mem_arbiter_n: fixed-priority and round-robin instances
// checked every cycle against a transaction-level reference model.
module tb_mem_arbiter_n;
  import mem_arb_pkg::*;

  localparam int N   = 3;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam int LIM = 4;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  logic [N-1:0]  req  [2];
  logic [N-1:0]  wr   [2];
  logic [N-1:0]  keep [2];
  logic [AW-1:0] addr [2][N];
  logic [DW-1:0] wd   [2][N];
  logic          rdy  [2];
  logic [DW-1:0] srd  [2];

  logic [N-1:0]  o_done  [2];
  logic [N-1:0]  o_stall [2];
  logic          o_sv    [2];
  logic          o_sw    [2];
  logic [AW-1:0] o_sa    [2];
  logic [DW-1:0] o_sd    [2];
  logic [DW-1:0] o_rd    [2];

  mem_arbiter_n_if #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
  ) bus0 ();
  mem_arbiter_n_if #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)
  ) bus1 ();

  mem_arbiter_n #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .ARB_MODE(ARB_FIXED), .STARVE_LIMIT(LIM)
  ) u_fix (.CLK(CLK), .RESET(RESET), .bus(bus0));

  mem_arbiter_n #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
    .ARB_MODE(ARB_RR), .STARVE_LIMIT(LIM)
  ) u_rr (.CLK(CLK), .RESET(RESET), .bus(bus1));

  assign bus0.m_req   = req[0];
  assign bus0.m_write = wr[0];
  assign bus0.m_addr  =
    {addr[0][2], addr[0][1], addr[0][0]};
  assign bus0.m_wdata = {wd[0][2], wd[0][1], wd[0][0]};
  assign bus0.s_ready = rdy[0];
  assign bus0.s_rdata = srd[0];
  assign bus1.m_req   = req[1];
  assign bus1.m_write = wr[1];
  assign bus1.m_addr  =
    {addr[1][2], addr[1][1], addr[1][0]};
  assign bus1.m_wdata = {wd[1][2], wd[1][1], wd[1][0]};
  assign bus1.s_ready = rdy[1];
  assign bus1.s_rdata = srd[1];

  assign o_done[0]  = bus0.m_done;
  assign o_stall[0] = bus0.m_stall;
  assign o_sv[0]    = bus0.s_valid;
  assign o_sw[0]    = bus0.s_write;
  assign o_sa[0]    = bus0.s_addr;
  assign o_sd[0]    = bus0.s_wdata;
  assign o_rd[0]    = bus0.m_rdata;
  assign o_done[1]  = bus1.m_done;
  assign o_stall[1] = bus1.m_stall;
  assign o_sv[1]    = bus1.s_valid;
  assign o_sw[1]    = bus1.s_write;
  assign o_sa[1]    = bus1.s_addr;
  assign o_sd[1]    = bus1.s_wdata;
  assign o_rd[1]    = bus1.m_rdata;

  bit            mbusy [2];
  int            mown  [2];
  int            mptr  [2];
  int            mcnt  [2][N];
  bit            msv   [2];
  logic          msw   [2];
  logic [AW-1:0] msa   [2];
  logic [DW-1:0] msd   [2];
  logic [DW-1:0] mrd   [2];
  logic [N-1:0]  mdone [2];

  task automatic model_reset(int d);
    mbusy[d] = 0;
    mown[d]  = 0;
    mptr[d]  = 0;
    msv[d]   = 0;
    msw[d]   = 0;
    msa[d]   = '0;
    msd[d]   = '0;
    mrd[d]   = '0;
    mdone[d] = '0;
    for (int i = 0; i < N; i++) mcnt[d][i] = 0;
  endtask

  function automatic int pick(
    int d, logic [N-1:0] elig
  );
`ifdef ARB_STARVE_GUARD_EN
    for (int i = 0; i < N; i++)
      if (elig[i] && mcnt[d][i] == LIM) return i;
`endif
    for (int k = 0; k < N; k++) begin
      int j = (d == 0) ? k : (mptr[d] + k) % N;
      if (elig[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_step(int d);
    bit           fin;
    logic [N-1:0] elig;
    int           w;
    fin      = mbusy[d] && rdy[d];
    elig     = req[d];
    mdone[d] = '0;
    if (fin) begin
      mdone[d][mown[d]] = 1'b1;
      mrd[d]            = srd[d];
      elig[mown[d]]     = 1'b0;
    end
    w = (mbusy[d] && !fin) ? -1 : pick(d, elig);
    for (int i = 0; i < N; i++) begin
      if (!req[d][i] || w == i) mcnt[d][i] = 0;
      else if (mcnt[d][i] < LIM) mcnt[d][i]++;
    end
    if (w >= 0) begin
      mbusy[d] = 1;
      mown[d]  = w;
      mptr[d]  = (w + 1) % N;
      msv[d]   = 1;
      msw[d]   = wr[d][w];
      msa[d]   = addr[d][w];
      msd[d]   = wd[d][w];
    end else if (fin) begin
      mbusy[d] = 0;
      msv[d]   = 0;
    end
  endtask

  task automatic check(int d);
    chk($sformatf("s_valid%0d", d), o_sv[d], msv[d]);
    if (msv[d]) begin
      chk($sformatf("s_addr%0d", d), o_sa[d], msa[d]);
      chk($sformatf("s_write%0d", d), o_sw[d], msw[d]);
      chk($sformatf("s_wdata%0d", d), o_sd[d], msd[d]);
    end
    chk($sformatf("m_done%0d", d), o_done[d], mdone[d]);
    if (mdone[d] != '0)
      chk($sformatf("m_rdata%0d", d), o_rd[d], mrd[d]);
    chk($sformatf("m_stall%0d", d), o_stall[d],
        req[d] & ~mdone[d]);
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      if (RESET) model_step(d);
      else model_reset(d);
    end
    @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      check(d);
      for (int i = 0; i < N; i++)
        if (o_done[d][i] && !keep[d][i])
          req[d][i] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 &&
         ((req[0] | req[1]) != '0 ||
          mbusy[0] || mbusy[1]); k++) begin
      rdy[0] = 1'b1;
      rdy[1] = 1'b1;
      tick();
    end
    chk("drain_req", {req[0], req[1]}, 6'b0);
    chk("drain_sv0", o_sv[0], 1'b0);
    chk("drain_sv1", o_sv[1], 1'b0);
  endtask

  int order[$];
  int exp_rr[6] = '{0, 1, 2, 0, 1, 2};
  int w;
  bit found;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d]  = '0;
      wr[d]   = '0;
      keep[d] = '0;
      rdy[d]  = 1'b0;
      srd[d]  = '0;
      for (int i = 0; i < N; i++) begin
        addr[d][i] = '0;
        wd[d][i]   = '0;
      end
      model_reset(d);
    end

    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      chk("rst_sv", o_sv[d], 1'b0);
      chk("rst_sw", o_sw[d], 1'b0);
      chk("rst_sa", o_sa[d], 64'h0);
      chk("rst_sd", o_sd[d], 64'h0);
      chk("rst_done", o_done[d], 3'b000);
      chk("rst_rdata", o_rd[d], 64'h0);
    end
    #2 RESET = 1'b1;

    addr[0][0] = 64'h100;
    addr[0][1] = 64'h200;
    wd[0][1]   = 64'h5555;
    wr[0]      = 3'b010;
    srd[0]     = 64'h1111;
    rdy[0]     = 1'b1;
    req[0]     = 3'b011;
    tick();
    chk("t1_sv_c1", o_sv[0], 1'b1);
    chk("t1_sa_c1", o_sa[0], 64'h100);
    tick();
    chk("t1_done_c2", o_done[0], 3'b001);
    chk("t1_rdata_c2", o_rd[0], 64'h1111);
    chk("t1_sv_c2", o_sv[0], 1'b1);
    chk("t1_sa_c2", o_sa[0], 64'h200);
    chk("t1_sw_c2", o_sw[0], 1'b1);
    tick();
    chk("t1_done_c3", o_done[0], 3'b010);
    chk("t1_sv_c3", o_sv[0], 1'b0);
    rdy[0] = 1'b0;
    wr[0]  = '0;

    addr[0][1] = 64'h80;
    keep[0]    = 3'b010;
    req[0]     = 3'b010;
    tick();
    chk("t2_sa_grant", o_sa[0], 64'h80);
    chk("t2_stall_grant", o_stall[0][1], 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_sa_hold", o_sa[0], 64'h80);
      chk("t2_stall_hold", o_stall[0][1], 1'b1);
    end
    rdy[0] = 1'b1;
    srd[0] = 64'hDEADBEEF;
    tick();
    chk("t2_done", o_done[0], 3'b010);
    chk("t2_rdata", o_rd[0], 64'hDEADBEEF);
    chk("t2_stall_done", o_stall[0][1], 1'b0);
    keep[0] = '0;
    req[0]  = '0;
    rdy[0]  = 1'b0;
    tick();

    for (int i = 0; i < N; i++)
      addr[1][i] = 64'h1000 + 64'(i * 16);
    req[1]  = 3'b111;
    keep[1] = 3'b111;
    rdy[1]  = 1'b1;
    for (int k = 0; k < 30 && order.size() < 6;
         k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (o_done[1][i]) order.push_back(i);
    end
    keep[1] = '0;
    drain();
    chk("rr_count", order.size(), 6);
    for (int k = 0; k < order.size() && k < 6; k++)
      chk($sformatf("rr_order%0d", k),
          order[k], exp_rr[k]);

    addr[0][0] = 64'h100;
    addr[0][1] = 64'h200;
    addr[0][2] = 64'hA2;
    req[0]     = 3'b111;
    keep[0]    = 3'b011;
    rdy[0]     = 1'b1;
    w          = 0;
    found      = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      w++;
      if (o_sv[0] && o_sa[0] == 64'hA2) found = 1;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_found", found, 1'b1);
    chk("starve_wait_le5", (w <= 5), 1'b1);
`else
    chk("starve_never", found, 1'b0);
`endif
    keep[0] = '0;
    drain();

    addr[0][0] = 64'h300;
    rdy[0]     = 1'b0;
    req[0]     = 3'b001;
    tick();
    chk("t5_sv_grant", o_sv[0], 1'b1);
    tick();
    #2 RESET = 1'b0;
    #1;
    chk("t5_sv_rst", o_sv[0], 1'b0);
    chk("t5_sa_rst", o_sa[0], 64'h0);
    chk("t5_done_rst", o_done[0], 3'b000);
    model_reset(0);
    model_reset(1);
    rdy[0] = 1'b1;
    tick();
    chk("t5_done_in_rst", o_done[0], 3'b000);
    #2 RESET = 1'b1;
    tick();
    chk("t5_regrant_sv", o_sv[0], 1'b1);
    chk("t5_regrant_sa", o_sa[0], 64'h300);
    tick();
    chk("t5_done_after", o_done[0], 3'b001);
    drain();

    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < N; i++) begin
          if (!req[d][i]) begin
            if ($urandom_range(0, 2) == 0) begin
              req[d][i]  = 1'b1;
              wr[d][i]   = 1'($urandom_range(0, 1));
              addr[d][i] = {$urandom, $urandom};
              wd[d][i]   = {$urandom, $urandom};
            end
          end else if (!(mbusy[d] && mown[d] == i) &&
                       $urandom_range(0, 15) == 0) begin
            req[d][i] = 1'b0;
          end
        end
        rdy[d] = 1'($urandom_range(0, 1));
        srd[d] = {$urandom, $urandom};
      end
      tick();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
